// File: rtl/sample_page_buffer.sv
// ---------------------------------------------------------------------------
// sample_page_buffer
//
// Stores sample packets from the logic-capture core in a circular RAM page.
// While capture runs, it accepts packets and raises page-full back-pressure
// when the page fills in linear mode. When capture is idle, it drains the
// stored packets oldest-first over a valid/ready stream.
//
// Ports:
//   clk           clock, all logic on the rising edge
//   reset         synchronous, active-high
//   clear         one-cycle flush of pointers/counters (RAM contents kept)
//   pkt_data      sample packet from the capture core
//   pkt_we        packet write strobe from the capture core
//   wrap_enable   1 = ring mode, overwrite the oldest entry when full
//   capture_idle  capture core idle: enables readout, blocks writes
//   page_full     registered back-pressure to the capture core
//   occupancy     stored entries, 0..DEPTH
//   drop_count    discarded writes, saturating at 16'hFFFF
//   rd_valid      rd_data / rd_last are valid
//   rd_ready      downstream accepts when rd_valid & rd_ready
//   rd_data       oldest stored packet
//   rd_last       with rd_valid: this is the final stored entry
// ---------------------------------------------------------------------------
module sample_page_buffer #(
  parameter int PACKET_WIDTH = 32,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [PACKET_WIDTH-1:0] pkt_data,
  input  logic                    pkt_we,
  input  logic                    wrap_enable,
  input  logic                    capture_idle,
  output logic                    page_full,
  output logic [ADDR_WIDTH:0]     occupancy,
  output logic [15:0]             drop_count,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [PACKET_WIDTH-1:0] rd_data,
  output logic                    rd_last
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   ONE_CNT  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_VALID = 2'd2
  } rd_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [PACKET_WIDTH-1:0] mem [DEPTH];
  logic [PACKET_WIDTH-1:0] ram_q;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   occ_next;

  rd_state_t state, state_next;

  logic                  is_full;
  logic                  wr_accept;
  logic                  wr_store;
  logic                  wr_grow;
  logic                  wr_over;
  logic                  wr_drop;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic                  rd_pop;
  logic                  load_data;
  logic                  valid_next;
  logic                  last_next;

  // Write-side decode. Full/empty comes only from occupancy; pointers wrap
  // silently and are never compared against each other.
  always_comb begin
    is_full   = (occupancy == FULL_CNT);
    wr_accept = pkt_we && !capture_idle;
    wr_store  = wr_accept && (!is_full || wrap_enable) && !reset && !clear;
    wr_grow   = wr_store && !is_full;
    wr_over   = wr_store && is_full;
    wr_drop   = pkt_we && (capture_idle || (is_full && !wrap_enable));
  end

  // Writes only happen with capture running and pops only with capture
  // idle, so at most one of grow/pop is active in any cycle.
  always_comb begin
    occ_next = occupancy;
    if (wr_grow)
      occ_next = occupancy + ONE_CNT;
    else if (rd_pop)
      occ_next = occupancy - ONE_CNT;
  end

  // Read FSM: next state and control.
  always_comb begin
    state_next = state;
    ram_re     = 1'b0;
    ram_raddr  = rd_ptr;
    rd_pop     = 1'b0;
    load_data  = 1'b0;
    valid_next = rd_valid;
    last_next  = rd_last;
    case (state)
      R_IDLE: begin
        valid_next = 1'b0;
        last_next  = 1'b0;
        if (capture_idle && (occupancy != '0)) begin
          ram_re     = 1'b1;
          state_next = R_FETCH;
        end
      end
      R_FETCH: begin
        if (!capture_idle) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          state_next = R_IDLE;
        end else begin
          load_data  = 1'b1;
          valid_next = 1'b1;
          last_next  = (occupancy == ONE_CNT);
          state_next = R_VALID;
        end
      end
      R_VALID: begin
        // Capture restarting takes precedence: the presented word is left
        // stored and will be re-fetched on the next idle period.
        if (!capture_idle) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          state_next = R_IDLE;
        end else if (rd_ready) begin
          rd_pop     = 1'b1;
          valid_next = 1'b0;
          last_next  = 1'b0;
          if (occupancy > ONE_CNT) begin
            // Prefetch the following entry in the handshake cycle.
            ram_re     = 1'b1;
            ram_raddr  = rd_ptr + PTR_ONE;
            state_next = R_FETCH;
          end else begin
            state_next = R_IDLE;
          end
        end
      end
      default: begin
        valid_next = 1'b0;
        last_next  = 1'b0;
        state_next = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear)
      state <= R_IDLE;
    else
      state <= state_next;
  end

  // Sample RAM: simple dual port, one-cycle synchronous read, no reset.
  always_ff @(posedge clk) begin
    if (wr_store)
      mem[wr_ptr] <= pkt_data;
    if (ram_re)
      ram_q <= mem[ram_raddr];
  end

  // Pointers, counters and stream control.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      drop_count <= '0;
      page_full  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      if (wr_store)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (wr_over || rd_pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      occupancy <= occ_next;
      if (wr_drop)
        drop_count <= sat_inc16(drop_count);
      page_full <= (occ_next == FULL_CNT) && !wrap_enable;
      rd_valid  <= valid_next;
      rd_last   <= last_next;
    end
  end

  // Output data register: cleared by reset only, so clear keeps the last word.
  always_ff @(posedge clk) begin
    if (reset)
      rd_data <= '0;
    else if (load_data && !clear)
      rd_data <= ram_q;
  end

endmodule

// File: tb/tb_sample_page_buffer.sv
module tb_sample_page_buffer;

  localparam int PW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [PW-1:0] pkt_data;
  logic          pkt_we;
  logic          wrap_enable;
  logic          capture_idle;
  logic          page_full;
  logic [AW:0]   occupancy;
  logic [15:0]   drop_count;
  logic          rd_valid;
  logic          rd_ready;
  logic [PW-1:0] rd_data;
  logic          rd_last;

  int compared   = 0;
  int mismatched = 0;

  sample_page_buffer #(.PACKET_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .pkt_data     (pkt_data),
    .pkt_we       (pkt_we),
    .wrap_enable  (wrap_enable),
    .capture_idle (capture_idle),
    .page_full    (page_full),
    .occupancy    (occupancy),
    .drop_count   (drop_count),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_last      (rd_last)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; pkt_data = '0; pkt_we = 1'b0;
    wrap_enable = 1'b0; capture_idle = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic write_pkt(input logic [PW-1:0] d);
    pkt_data = d; pkt_we = 1'b1;
    tick();
    pkt_we = 1'b0;
  endtask

  // Waits (bounded) for rd_valid and returns the presented word; no checking.
  task automatic get_word(output logic [PW-1:0] d, output logic l, output bit ok);
    ok = 1'b0; d = '0; l = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rd_valid === 1'b1) begin
        d = rd_data; l = rd_last; ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (occupancy !== '0 || drop_count !== 16'd0 || page_full !== 1'b0 ||
        rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== '0) begin
      mismatched++;
      $display("FAIL reset_state: occ=%0d drop=%0d pf=%b vld=%b last=%b data=%h, required all zero",
               occupancy, drop_count, page_full, rd_valid, rd_last, rd_data);
    end
  endtask

  task automatic test_basic();
    logic [PW-1:0] d; logic l; bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) write_pkt(PW'(32'h11 + i));
    compared++;
    if (occupancy !== 5'd5) begin
      mismatched++; $display("FAIL basic_occ5: got %0d, required 5", occupancy);
    end
    capture_idle = 1'b1; rd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      get_word(d, l, ok);
      compared++;
      if (!ok || d !== PW'(32'h11 + k) || l !== (k == 4)) begin
        mismatched++;
        $display("FAIL basic_word%0d: ok=%b data=%h last=%b, required data=%h last=%b",
                 k, ok, d, l, 32'h11 + k, (k == 4));
      end
      compared++;
      if (occupancy !== 5'(5 - k)) begin
        mismatched++; $display("FAIL basic_occ_word%0d: got %0d, required %0d", k, occupancy, 5 - k);
      end
      tick();
    end
    tick(); tick();
    compared++;
    if (occupancy !== 5'd0 || page_full !== 1'b0 || rd_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_drained: occ=%0d pf=%b vld=%b, required 0/0/0", occupancy, page_full, rd_valid);
    end
  endtask

  task automatic test_full_nowrap();
    logic [PW-1:0] d; logic l; bit ok;
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) begin
      write_pkt(PW'(i));
      if (i == DEPTH - 2) begin
        compared++;
        if (page_full !== 1'b0) begin
          mismatched++; $display("FAIL nowrap_pf_early: got %b, required 0", page_full);
        end
      end
      if (i == DEPTH - 1) begin
        compared++;
        if (page_full !== 1'b1) begin
          mismatched++; $display("FAIL nowrap_pf_set: got %b, required 1", page_full);
        end
      end
    end
    compared++;
    if (drop_count !== 16'd3 || occupancy !== 5'(DEPTH)) begin
      mismatched++;
      $display("FAIL nowrap_counts: drop=%0d occ=%0d, required 3/%0d", drop_count, occupancy, DEPTH);
    end
    capture_idle = 1'b1; rd_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      get_word(d, l, ok);
      compared++;
      if (!ok || d !== PW'(k) || l !== (k == DEPTH - 1)) begin
        mismatched++;
        $display("FAIL nowrap_word%0d: ok=%b data=%h last=%b, required data=%h last=%b",
                 k, ok, d, l, k, (k == DEPTH - 1));
      end
      tick();
    end
    compared++;
    if (occupancy !== 5'd0 || page_full !== 1'b0) begin
      mismatched++; $display("FAIL nowrap_drained: occ=%0d pf=%b, required 0/0", occupancy, page_full);
    end
  endtask

  task automatic test_wrap_then_fall();
    logic [PW-1:0] d; logic l; bit ok; bit pf_seen;
    do_reset();
    wrap_enable = 1'b1;
    pf_seen = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      write_pkt(PW'(i));
      if (page_full !== 1'b0) pf_seen = 1'b1;
    end
    compared++;
    if (pf_seen || occupancy !== 5'(DEPTH) || drop_count !== 16'd0) begin
      mismatched++;
      $display("FAIL wrap_state: pf_seen=%b occ=%0d drop=%0d, required 0/%0d/0",
               pf_seen, occupancy, drop_count, DEPTH);
    end
    wrap_enable = 1'b0;
    tick();
    compared++;
    if (page_full !== 1'b1) begin
      mismatched++; $display("FAIL wrap_fall_pf: got %b, required 1", page_full);
    end
    write_pkt(32'hDEAD_BEEF);
    compared++;
    if (drop_count !== 16'd1 || occupancy !== 5'(DEPTH)) begin
      mismatched++;
      $display("FAIL wrap_fall_drop: drop=%0d occ=%0d, required 1/%0d", drop_count, occupancy, DEPTH);
    end
    capture_idle = 1'b1; rd_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      get_word(d, l, ok);
      compared++;
      if (!ok || d !== PW'(k + 4) || l !== (k == DEPTH - 1)) begin
        mismatched++;
        $display("FAIL wrap_word%0d: ok=%b data=%h last=%b, required data=%h last=%b",
                 k, ok, d, l, k + 4, (k == DEPTH - 1));
      end
      tick();
    end
  endtask

  task automatic test_stall_abort();
    logic [PW-1:0] d; logic l; bit ok; int unstable;
    do_reset();
    for (int i = 0; i < 3; i++) write_pkt(PW'(32'hA0 + i));
    capture_idle = 1'b1; rd_ready = 1'b0;
    get_word(d, l, ok);
    compared++;
    if (!ok || d !== 32'hA0 || l !== 1'b0) begin
      mismatched++; $display("FAIL stall_first: ok=%b data=%h last=%b, required A0/0", ok, d, l);
    end
    unstable = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rd_valid !== 1'b1 || rd_data !== 32'hA0 || rd_last !== 1'b0) unstable++;
    end
    compared++;
    if (unstable != 0 || occupancy !== 5'd3) begin
      mismatched++;
      $display("FAIL stall_hold: unstable_cycles=%0d occ=%0d, required 0/3", unstable, occupancy);
    end
    capture_idle = 1'b0;
    tick();
    compared++;
    if (rd_valid !== 1'b0 || occupancy !== 5'd3) begin
      mismatched++; $display("FAIL abort: vld=%b occ=%0d, required 0/3", rd_valid, occupancy);
    end
    tick(); tick();
    capture_idle = 1'b1; rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      get_word(d, l, ok);
      compared++;
      if (!ok || d !== PW'(32'hA0 + k) || l !== (k == 2)) begin
        mismatched++;
        $display("FAIL resume_word%0d: ok=%b data=%h last=%b, required data=%h last=%b",
                 k, ok, d, l, 32'hA0 + k, (k == 2));
      end
      tick();
    end
  endtask

  task automatic test_clear();
    int vld_seen;
    do_reset();
    capture_idle = 1'b1;
    write_pkt(32'h55);
    capture_idle = 1'b0;
    for (int i = 0; i < 7; i++) write_pkt(PW'(32'h70 + i));
    compared++;
    if (occupancy !== 5'd7 || drop_count !== 16'd1) begin
      mismatched++; $display("FAIL clear_pre: occ=%0d drop=%0d, required 7/1", occupancy, drop_count);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    compared++;
    if (occupancy !== 5'd0 || drop_count !== 16'd0 || page_full !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_flush: occ=%0d drop=%0d pf=%b, required 0/0/0", occupancy, drop_count, page_full);
    end
    capture_idle = 1'b1; rd_ready = 1'b1;
    vld_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rd_valid !== 1'b0) vld_seen++;
    end
    compared++;
    if (vld_seen != 0) begin
      mismatched++; $display("FAIL clear_no_valid: valid_cycles=%0d, required 0", vld_seen);
    end
    write_pkt(32'h99);
    compared++;
    if (drop_count !== 16'd1 || occupancy !== 5'd0) begin
      mismatched++; $display("FAIL idle_drop: drop=%0d occ=%0d, required 1/0", drop_count, occupancy);
    end
  endtask

  task automatic test_drop_saturate();
    // Continues from test_clear: drop_count is 1, capture idle, buffer empty.
    pkt_data = '0; pkt_we = 1'b1;
    for (int c = 0; c < 65540; c++) tick();
    pkt_we = 1'b0;
    tick();
    compared++;
    if (drop_count !== 16'hFFFF) begin
      mismatched++; $display("FAIL drop_saturate: got %h, required ffff", drop_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_nowrap();
    test_wrap_then_fall();
    test_stall_abort();
    test_clear();
    test_drop_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
